// File: rtl/dvp_pkg.sv
// Shared definitions for the DVP transmitter: the FSM state encoding, the
// default frame timing and the RGB565 colour-bar palette used by the
// optional test-pattern generator.
package dvp_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_VSYNC  = 3'd1,
        ST_VBACK  = 3'd2,
        ST_LINE   = 3'd3,
        ST_HBLANK = 3'd4,
        ST_VFRONT = 3'd5
    } dvp_state_e;

    localparam int DEF_H_ACTIVE   = 640;
    localparam int DEF_V_ACTIVE   = 480;
    localparam int DEF_H_BLANK    = 144;
    localparam int DEF_VSYNC_LEN  = 3;
    localparam int DEF_VBACK_LEN  = 17;
    localparam int DEF_VFRONT_LEN = 10;

    // Wide enough for any phase length, including 2*H_ACTIVE byte cycles.
    localparam int CNT_W = 16;

    localparam logic [15:0] BAR_WHITE   = 16'hFFFF;
    localparam logic [15:0] BAR_YELLOW  = 16'hFFE0;
    localparam logic [15:0] BAR_CYAN    = 16'h07FF;
    localparam logic [15:0] BAR_GREEN   = 16'h07E0;
    localparam logic [15:0] BAR_MAGENTA = 16'hF81F;
    localparam logic [15:0] BAR_RED     = 16'hF800;
    localparam logic [15:0] BAR_BLUE    = 16'h001F;
    localparam logic [15:0] BAR_BLACK   = 16'h0000;

    // Bar colour for bar index 0 (leftmost) to 7 (rightmost).
    function automatic logic [15:0] bar_colour(input logic [2:0] idx);
        logic [15:0] c;
        case (idx)
            3'd0:    c = BAR_WHITE;
            3'd1:    c = BAR_YELLOW;
            3'd2:    c = BAR_CYAN;
            3'd3:    c = BAR_GREEN;
            3'd4:    c = BAR_MAGENTA;
            3'd5:    c = BAR_RED;
            3'd6:    c = BAR_BLUE;
            default: c = BAR_BLACK;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/dvp_pattern_gen.sv
// Colour-bar source for the DVP transmitter. Maps the pixel column to one of
// eight equal-width bars; the last bar absorbs the remainder of H_ACTIVE/8.
// Only instantiated when DVP_TX_TEST_PATTERN_EN is defined.
module dvp_pattern_gen
    import dvp_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE
) (
    input  logic [9:0]  i_xIndex,
    output logic [15:0] o_pixel
);

    // Lines narrower than 8 pixels still get one pixel per bar.
    localparam int BAR_W = (H_ACTIVE >= 8) ? (H_ACTIVE / 8) : 1;

    logic [9:0] bar_raw;
    logic [2:0] bar_idx;

    // Column to bar index, clamped so leftover pixels stay in the last bar.
    always_comb begin
        bar_raw = i_xIndex / 10'(BAR_W);
        bar_idx = (bar_raw > 10'd7) ? 3'd7 : bar_raw[2:0];
    end

    assign o_pixel = bar_colour(bar_idx);

endmodule

// File: rtl/dvp_transmitter.sv
// DVP (camera-style) transmitter: serialises an RGB565 pixel stream into
// vsync/href/8-bit data, high byte first, two byte cycles per pixel.
// Optional colour-bar test pattern is built only with DVP_TX_TEST_PATTERN_EN.
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | waiting for i_start, all bus outputs low
// VSYNC   | vertical sync pulse, VSYNC_LEN cycles
// VBACK   | vertical back porch, VBACK_LEN cycles
// LINE    | active line, 2*H_ACTIVE byte cycles, pixel accepted on phase 0
// HBLANK  | href low between lines, H_BLANK cycles
// VFRONT  | vertical front porch, VFRONT_LEN cycles, frame done on exit
module dvp_transmitter
    import dvp_pkg::*;
#(
    parameter int H_ACTIVE   = DEF_H_ACTIVE,
    parameter int V_ACTIVE   = DEF_V_ACTIVE,
    parameter int H_BLANK    = DEF_H_BLANK,
    parameter int VSYNC_LEN  = DEF_VSYNC_LEN,
    parameter int VBACK_LEN  = DEF_VBACK_LEN,
    parameter int VFRONT_LEN = DEF_VFRONT_LEN
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_start,
    input  logic        i_continuous,
    input  logic        i_testMode,
    input  logic [15:0] i_pixelData,
    input  logic        i_pixelValid,
    output logic        o_pixelReady,
    output logic        o_vsync,
    output logic        o_href,
    output logic [7:0]  o_data,
    output logic        o_busy,
    output logic        o_frameDone,
    output logic        o_underrun,
    output logic [9:0]  o_xIndex,
    output logic [9:0]  o_yIndex
);

    // Down-counter reload values: each phase runs until the counter hits 0.
    localparam logic [CNT_W-1:0] VSYNC_LAST  = CNT_W'(VSYNC_LEN - 1);
    localparam logic [CNT_W-1:0] VBACK_LAST  = CNT_W'(VBACK_LEN - 1);
    localparam logic [CNT_W-1:0] LINE_LAST   = CNT_W'(2 * H_ACTIVE - 1);
    localparam logic [CNT_W-1:0] HBLANK_LAST = CNT_W'(H_BLANK - 1);
    localparam logic [CNT_W-1:0] VFRONT_LAST = CNT_W'(VFRONT_LEN - 1);
    localparam logic [9:0]       Y_LAST      = 10'(V_ACTIVE - 1);

    dvp_state_e       state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             phase_q;
    logic [9:0]       x_q;
    logic [9:0]       y_q;
    logic             frame_done_q;
    logic             vsync_q;
    logic             href_q;
    logic             underrun_q;
    logic [7:0]       data_q;
    logic [7:0]       lo_q;
    logic [15:0]      pix_d;
    logic             use_pattern;
    logic             cnt_tc;

    assign cnt_tc = (cnt_q == '0);

`ifdef DVP_TX_TEST_PATTERN_EN
    logic        test_q;
    logic [15:0] bar_pixel;

    dvp_pattern_gen #(
        .H_ACTIVE (H_ACTIVE)
    ) u_pattern (
        .i_xIndex (x_q),
        .o_pixel  (bar_pixel)
    );

    // Test mode is sampled only outside active video so a frame never mixes sources.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            test_q <= 1'b0;
        end else if (state_q == ST_IDLE || state_q == ST_VSYNC) begin
            test_q <= i_testMode;
        end
    end

    assign use_pattern = test_q;

    // Pixel source: colour bars in test mode, otherwise the stream or zero on underrun.
    always_comb begin
        pix_d = i_pixelValid ? i_pixelData : 16'h0000;
        if (use_pattern) begin
            pix_d = bar_pixel;
        end
    end
`else
    logic unused_test_mode;
    assign unused_test_mode = i_testMode;
    assign use_pattern      = 1'b0;

    // Pixel source: the input stream, or zero when the source has nothing ready.
    always_comb begin
        pix_d = i_pixelValid ? i_pixelData : 16'h0000;
    end
`endif

    // Frame sequencing FSM with phase timer and pixel/line counters.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            phase_q      <= 1'b0;
            x_q          <= '0;
            y_q          <= '0;
            frame_done_q <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (i_start) begin
                        state_q <= ST_VSYNC;
                        cnt_q   <= VSYNC_LAST;
                        x_q     <= '0;
                        y_q     <= '0;
                    end
                end
                ST_VSYNC: begin
                    if (cnt_tc) begin
                        state_q <= ST_VBACK;
                        cnt_q   <= VBACK_LAST;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                ST_VBACK: begin
                    if (cnt_tc) begin
                        state_q <= ST_LINE;
                        cnt_q   <= LINE_LAST;
                        phase_q <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                ST_LINE: begin
                    phase_q <= ~phase_q;
                    if (phase_q) begin
                        x_q <= x_q + 10'd1;
                    end
                    if (cnt_tc) begin
                        state_q <= ST_HBLANK;
                        cnt_q   <= HBLANK_LAST;
                        phase_q <= 1'b0;
                        x_q     <= '0;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                ST_HBLANK: begin
                    if (cnt_tc) begin
                        if (y_q == Y_LAST) begin
                            state_q <= ST_VFRONT;
                            cnt_q   <= VFRONT_LAST;
                        end else begin
                            state_q <= ST_LINE;
                            cnt_q   <= LINE_LAST;
                            y_q     <= y_q + 10'd1;
                        end
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                ST_VFRONT: begin
                    if (cnt_tc) begin
                        frame_done_q <= 1'b1;
                        if (i_continuous) begin
                            state_q <= ST_VSYNC;
                            cnt_q   <= VSYNC_LAST;
                            y_q     <= '0;
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    // Registered DVP bus: sync flags and data lag the FSM by one cycle so they line up.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            vsync_q    <= 1'b0;
            href_q     <= 1'b0;
            data_q     <= 8'h00;
            lo_q       <= 8'h00;
            underrun_q <= 1'b0;
        end else begin
            vsync_q    <= (state_q == ST_VSYNC);
            href_q     <= (state_q == ST_LINE);
            data_q     <= 8'h00;
            underrun_q <= 1'b0;
            if (state_q == ST_LINE) begin
                if (!phase_q) begin
                    data_q     <= pix_d[15:8];
                    lo_q       <= pix_d[7:0];
                    underrun_q <= !use_pattern && !i_pixelValid;
                end else begin
                    data_q <= lo_q;
                end
            end
        end
    end

    assign o_pixelReady = (state_q == ST_LINE) && !phase_q && !use_pattern;
    assign o_busy       = (state_q != ST_IDLE);
    assign o_vsync      = vsync_q;
    assign o_href       = href_q;
    assign o_data       = data_q;
    assign o_frameDone  = frame_done_q;
    assign o_underrun   = underrun_q;
    assign o_xIndex     = x_q;
    assign o_yIndex     = y_q;

endmodule

// File: tb/tb_dvp_transmitter.sv
// Self-checking bench for dvp_transmitter with a small frame geometry.
// Build with DVP_TX_TEST_PATTERN_EN to also exercise the colour-bar mode.
module tb_dvp_transmitter;

    localparam int HA = 4;
    localparam int VA = 2;
    localparam int HB = 3;
    localparam int VS = 2;
    localparam int VB = 2;
    localparam int VF = 2;
    localparam int LL = 2 * HA + HB;
    localparam int FL = VS + VB + VA * LL + VF;
    localparam int MAXC = 200;

    localparam int K_OUT  = 0;
    localparam int K_VS   = 1;
    localparam int K_VB   = 2;
    localparam int K_LINE = 3;
    localparam int K_HB   = 4;
    localparam int K_VF   = 5;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        cont = 1'b0;
    logic        tmode = 1'b0;
    logic        valid = 1'b0;
    logic [15:0] pdata = 16'h0000;

    logic        o_pixelReady, o_vsync, o_href, o_busy, o_frameDone, o_underrun;
    logic [7:0]  o_data;
    logic [9:0]  o_xIndex, o_yIndex;

    int n_tests = 0;
    int n_fail  = 0;

    logic        v_hist [MAXC];
    logic [15:0] d_hist [MAXC];

    dvp_transmitter #(
        .H_ACTIVE   (HA),
        .V_ACTIVE   (VA),
        .H_BLANK    (HB),
        .VSYNC_LEN  (VS),
        .VBACK_LEN  (VB),
        .VFRONT_LEN (VF)
    ) dut (
        .i_clk        (clk),
        .i_reset      (rst),
        .i_start      (start),
        .i_continuous (cont),
        .i_testMode   (tmode),
        .i_pixelData  (pdata),
        .i_pixelValid (valid),
        .o_pixelReady (o_pixelReady),
        .o_vsync      (o_vsync),
        .o_href       (o_href),
        .o_data       (o_data),
        .o_busy       (o_busy),
        .o_frameDone  (o_frameDone),
        .o_underrun   (o_underrun),
        .o_xIndex     (o_xIndex),
        .o_yIndex     (o_yIndex)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Where cycle s (counted from the start edge) falls in a run of nfr frames.
    function automatic void region(input int s, input int nfr,
                                   output int kind, output int line, output int pos);
        int r;
        kind = K_OUT;
        line = 0;
        pos  = 0;
        if (s < 0 || s >= nfr * FL) return;
        r = s % FL;
        if (r < VS) begin
            kind = K_VS;
        end else if (r < VS + VB) begin
            kind = K_VB;
        end else if (r < VS + VB + VA * LL) begin
            r    = r - (VS + VB);
            line = r / LL;
            pos  = r % LL;
            kind = (pos < 2 * HA) ? K_LINE : K_HB;
        end else begin
            kind = K_VF;
            line = VA - 1;
        end
    endfunction

    function automatic logic [15:0] sent(input int t);
        if (t < 0) return 16'h0000;
        return v_hist[t] ? d_hist[t] : 16'h0000;
    endfunction

    task automatic all_zero(input string tag);
        chk({tag, "_ready"},  o_pixelReady, 0);
        chk({tag, "_vsync"},  o_vsync, 0);
        chk({tag, "_href"},   o_href, 0);
        chk({tag, "_data"},   o_data, 0);
        chk({tag, "_busy"},   o_busy, 0);
        chk({tag, "_done"},   o_frameDone, 0);
        chk({tag, "_under"},  o_underrun, 0);
        chk({tag, "_x"},      o_xIndex, 0);
        chk({tag, "_y"},      o_yIndex, 0);
    endtask

    // Random pixels/valids over nfr frames, compared cycle by cycle with the timeline model.
    task automatic run_model(input int nfr);
        int k, ln, ps, k1, ln1, ps1;
        logic [7:0] exp_data;
        logic       exp_und;
        cont  = (nfr > 1);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 0; c <= nfr * FL + 3; c++) begin
            region(c, nfr, k, ln, ps);
            region(c - 1, nfr, k1, ln1, ps1);
            chk("busy", o_busy, k != K_OUT);
            chk("pixelReady", o_pixelReady, (k == K_LINE) && (ps % 2 == 0));
            chk("xIndex", o_xIndex, (k == K_LINE) ? ps / 2 : 0);
            if (k != K_OUT) chk("yIndex", o_yIndex, (k == K_VS || k == K_VB) ? 0 : ln);
            chk("vsync", o_vsync, k1 == K_VS);
            chk("href", o_href, k1 == K_LINE);
            exp_data = 8'h00;
            exp_und  = 1'b0;
            if (k1 == K_LINE) begin
                if (ps1 % 2 == 0) begin
                    exp_data = sent(c - 1) >> 8;
                    exp_und  = !v_hist[c - 1];
                end else begin
                    exp_data = 8'(sent(c - 2));
                end
            end
            chk("data", o_data, exp_data);
            chk("underrun", o_underrun, exp_und);
            chk("frameDone", o_frameDone, (c > 0) && (c % FL == 0) && (c <= nfr * FL));
            valid     = ($urandom_range(0, 5) != 0);
            pdata     = 16'($urandom);
            v_hist[c] = valid;
            d_hist[c] = pdata;
            if (c == (nfr - 1) * FL + 5) cont = 1'b0;
            tick();
        end
        valid = 1'b0;
    endtask

    typedef struct {
        logic [15:0] pix;
        logic        vld;
        logic [7:0]  hi;
        logic [7:0]  lo;
        logic        und;
    } vec_t;

    vec_t tbl [4];

`ifdef DVP_TX_TEST_PATTERN_EN
    logic        start_tp = 1'b0;
    logic        tmode_tp = 1'b1;
    logic        tp_ready, tp_vsync, tp_href, tp_busy, tp_done, tp_under;
    logic [7:0]  tp_data;
    logic [9:0]  tp_x, tp_y;
    logic [15:0] tp_bars [8];

    dvp_transmitter #(
        .H_ACTIVE   (16),
        .V_ACTIVE   (1),
        .H_BLANK    (HB),
        .VSYNC_LEN  (VS),
        .VBACK_LEN  (VB),
        .VFRONT_LEN (VF)
    ) dut_tp (
        .i_clk        (clk),
        .i_reset      (rst),
        .i_start      (start_tp),
        .i_continuous (1'b0),
        .i_testMode   (tmode_tp),
        .i_pixelData  (pdata),
        .i_pixelValid (valid),
        .o_pixelReady (tp_ready),
        .o_vsync      (tp_vsync),
        .o_href       (tp_href),
        .o_data       (tp_data),
        .o_busy       (tp_busy),
        .o_frameDone  (tp_done),
        .o_underrun   (tp_under),
        .o_xIndex     (tp_x),
        .o_yIndex     (tp_y)
    );
`endif

    initial begin
        int guard;
        int href_cnt;
        int done_cnt;
        int und_cnt;

        // Reset state and staying idle after release without a start.
        tick(); tick();
        all_zero("reset");
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("idle_busy", o_busy, 0);
            chk("idle_vsync", o_vsync, 0);
        end

        // Table-driven line 0 with an underrun on the third pixel.
        tbl[0] = '{16'h1234, 1'b1, 8'h12, 8'h34, 1'b0};
        tbl[1] = '{16'h5678, 1'b1, 8'h56, 8'h78, 1'b0};
        tbl[2] = '{16'h9ABC, 1'b0, 8'h00, 8'h00, 1'b1};
        tbl[3] = '{16'hDEF0, 1'b1, 8'hDE, 8'hF0, 1'b0};
        valid = 1'b1;
        pdata = 16'h0F0F;
        start = 1'b1;
        tick();
        start = 1'b0;
        guard = 0;
        while (!o_pixelReady && guard < 50) begin
            tick();
            guard++;
        end
        chk("tbl_ready_seen", guard < 50, 1);
        chk("tbl_ready_delay", guard, VS + VB);
        for (int i = 0; i < 4; i++) begin
            pdata = tbl[i].pix;
            valid = tbl[i].vld;
            chk("tbl_ready", o_pixelReady, 1);
            tick();
            valid = 1'b1;
            pdata = 16'h0F0F;
            chk("tbl_hi", o_data, tbl[i].hi);
            chk("tbl_under", o_underrun, tbl[i].und);
            chk("tbl_href_hi", o_href, 1);
            chk("tbl_noready", o_pixelReady, 0);
            tick();
            chk("tbl_lo", o_data, tbl[i].lo);
            chk("tbl_href_lo", o_href, 1);
        end
        tick();
        chk("tbl_href_end", o_href, 0);
        href_cnt = 0;
        done_cnt = 0;
        und_cnt  = 0;
        guard    = 0;
        while (o_busy && guard < 100) begin
            href_cnt += o_href;
            done_cnt += o_frameDone;
            und_cnt  += o_underrun;
            tick();
            guard++;
        end
        done_cnt += o_frameDone;
        chk("tbl_finish", guard < 100, 1);
        chk("tbl_line1_len", href_cnt, 2 * HA);
        chk("tbl_done_cnt", done_cnt, 1);
        chk("tbl_no_more_under", und_cnt, 0);
        valid = 1'b0;
        tick();

        // Randomised frames: single, continuous pair, continuous triple.
        run_model(1);
        run_model(2);
        run_model(3);

        // Reset during the third byte of line 1.
        valid = 1'b1;
        pdata = 16'hA55A;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < VS + VB + LL + 3; i++) tick();
        chk("rst_pre_href", o_href, 1);
        chk("rst_pre_data", o_data, 8'hA5);
        chk("rst_pre_y", o_yIndex, 1);
        rst = 1'b1;
        #1;
        all_zero("rst_mid");
        tick();
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("rst_idle_busy", o_busy, 0);
            chk("rst_idle_href", o_href, 0);
        end
        valid = 1'b0;

        // Restart after the mid-frame reset.
        run_model(1);

`ifdef DVP_TX_TEST_PATTERN_EN
        tp_bars[0] = 16'hFFFF; tp_bars[1] = 16'hFFE0;
        tp_bars[2] = 16'h07FF; tp_bars[3] = 16'h07E0;
        tp_bars[4] = 16'hF81F; tp_bars[5] = 16'hF800;
        tp_bars[6] = 16'h001F; tp_bars[7] = 16'h0000;
        begin
            int nb;
            logic [15:0] col;
            nb = 0;
            start_tp = 1'b1;
            tick();
            start_tp = 1'b0;
            for (int c = 0; c < 120; c++) begin
                valid = $urandom_range(0, 1);
                if (tp_href) begin
                    col = tp_bars[(nb / 2) / 2];
                    chk("tp_byte", tp_data, (nb % 2 == 0) ? col[15:8] : col[7:0]);
                    nb++;
                end
                chk("tp_ready", tp_ready, 0);
                chk("tp_under", tp_under, 0);
                tick();
            end
            chk("tp_bytes", nb, 32);
            chk("tp_idle", tp_busy, 0);
        end
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
